countdown_timer_hms_bcd: RTL and testbench

BCD hours/minutes/seconds countdown timer, the decrementing counterpart of the time-of-day counter, sharing its 1 Hz tick and digit output format. The user presets a duration with the same inc_hour/inc_min/inc_sec pulses, then starts, pauses or cancels the countdown. On reaching 00:00:00 the block raises an alarm for a bounded number of seconds. Digit outputs feed the same display path as the clock counter.

---
 rtl/countdown_timer_hms_bcd.sv | 197 +++++++++++++++++++
 tb/tb_countdown_timer_hms_bcd.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_hms_bcd.sv
// BCD hh:mm:ss countdown timer with an IDLE preset editor, pause/resume, and
// an alarm that holds for ALARM_SECS ticks after the count reaches zero.
module countdown_timer_hms_bcd #(
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       start_stop,
  input  logic       cancel,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hour_ones,
  output logic [1:0] hour_tens,
  output logic       running,
  output logic       paused,
  output logic       alarm,
  output logic       done_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);

  state_t     state_q, state_d;
  logic [3:0] sec_ones_q, sec_ones_d, sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d, min_tens_q, min_tens_d;
  logic [3:0] hour_ones_q, hour_ones_d;
  logic [1:0] hour_tens_q, hour_tens_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;
  logic       done_q, done_d;
  logic       hours_zero, mins_zero, is_zero, is_one;

  assign hours_zero = (hour_tens_q == 2'd0) && (hour_ones_q == 4'd0);
  assign mins_zero  = (min_tens_q == 4'd0) && (min_ones_q == 4'd0);
  assign is_zero    = hours_zero && mins_zero && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
  assign is_one     = hours_zero && mins_zero && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd1);

  always_comb begin
    state_d     = state_q;
    sec_ones_d  = sec_ones_q;
    sec_tens_d  = sec_tens_q;
    min_ones_d  = min_ones_q;
    min_tens_d  = min_tens_q;
    hour_ones_d = hour_ones_q;
    hour_tens_d = hour_tens_q;
    alarm_cnt_d = alarm_cnt_q;
    done_d      = 1'b0;

    if (cancel) begin
      state_d     = IDLE;
      sec_ones_d  = 4'd0;
      sec_tens_d  = 4'd0;
      min_ones_d  = 4'd0;
      min_tens_d  = 4'd0;
      hour_ones_d = 4'd0;
      hour_tens_d = 2'd0;
      alarm_cnt_d = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_stop) begin
            if (!is_zero) state_d = RUN;
          end else begin
            // Preset editing: each field wraps on its own, no carry.
            if (inc_sec) begin
              if (sec_ones_q == 4'd9) begin
                sec_ones_d = 4'd0;
                sec_tens_d = (sec_tens_q == 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
              end else begin
                sec_ones_d = sec_ones_q + 4'd1;
              end
            end
            if (inc_min) begin
              if (min_ones_q == 4'd9) begin
                min_ones_d = 4'd0;
                min_tens_d = (min_tens_q == 4'd5) ? 4'd0 : min_tens_q + 4'd1;
              end else begin
                min_ones_d = min_ones_q + 4'd1;
              end
            end
            if (inc_hour) begin
              if (hour_tens_q == 2'd2 && hour_ones_q == 4'd3) begin
                hour_tens_d = 2'd0;
                hour_ones_d = 4'd0;
              end else if (hour_ones_q == 4'd9) begin
                hour_ones_d = 4'd0;
                hour_tens_d = hour_tens_q + 2'd1;
              end else begin
                hour_ones_d = hour_ones_q + 4'd1;
              end
            end
          end
        end

        RUN: begin
          if (start_stop) begin
            state_d = PAUSE;
          end else if (tick_1hz && !is_zero) begin
            // One-second decrement with a BCD borrow ripple up to the hours.
            if (sec_ones_q != 4'd0) begin
              sec_ones_d = sec_ones_q - 4'd1;
            end else begin
              sec_ones_d = 4'd9;
              if (sec_tens_q != 4'd0) begin
                sec_tens_d = sec_tens_q - 4'd1;
              end else begin
                sec_tens_d = 4'd5;
                if (min_ones_q != 4'd0) begin
                  min_ones_d = min_ones_q - 4'd1;
                end else begin
                  min_ones_d = 4'd9;
                  if (min_tens_q != 4'd0) begin
                    min_tens_d = min_tens_q - 4'd1;
                  end else begin
                    min_tens_d = 4'd5;
                    if (hour_ones_q != 4'd0) begin
                      hour_ones_d = hour_ones_q - 4'd1;
                    end else begin
                      hour_ones_d = 4'd9;
                      hour_tens_d = hour_tens_q - 2'd1;
                    end
                  end
                end
              end
            end
            if (is_one) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end

        PAUSE: begin
          if (start_stop) state_d = RUN;
        end

        EXPIRED: begin
          if (start_stop) begin
            state_d     = IDLE;
            alarm_cnt_d = 8'd0;
          end else if (tick_1hz) begin
            if (alarm_cnt_q == ALARM_LAST) begin
              state_d     = IDLE;
              alarm_cnt_d = 8'd0;
            end else begin
              alarm_cnt_d = alarm_cnt_q + 8'd1;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sec_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      min_tens_q  <= 4'd0;
      hour_ones_q <= 4'd0;
      hour_tens_q <= 2'd0;
      alarm_cnt_q <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      hour_ones_q <= hour_ones_d;
      hour_tens_q <= hour_tens_d;
      alarm_cnt_q <= alarm_cnt_d;
      done_q      <= done_d;
    end
  end

  assign sec_ones   = sec_ones_q;
  assign sec_tens   = sec_tens_q;
  assign min_ones   = min_ones_q;
  assign min_tens   = min_tens_q;
  assign hour_ones  = hour_ones_q;
  assign hour_tens  = hour_tens_q;
  assign running    = (state_q == RUN);
  assign paused     = (state_q == PAUSE);
  assign alarm      = (state_q == EXPIRED);
  assign done_pulse = done_q;

endmodule

// File: tb/tb_countdown_timer_hms_bcd.sv
// Self-checking bench: directed scenarios plus random pulses, compared against
// a seconds-count reference model of the countdown timer.
module tb_countdown_timer_hms_bcd;

  localparam int ALARM = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, start_stop, cancel, inc_hour, inc_min, inc_sec;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones;
  logic [1:0] hour_tens;
  logic       running, paused, alarm, done_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 run, 2 pause, 3 expired; time kept as h/m/s integers.
  int m_state, m_h, m_m, m_s, m_cnt, m_done;

  countdown_timer_hms_bcd #(.ALARM_SECS(ALARM)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .start_stop(start_stop),
    .cancel(cancel), .inc_hour(inc_hour), .inc_min(inc_min), .inc_sec(inc_sec),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .hour_ones(hour_ones), .hour_tens(hour_tens),
    .running(running), .paused(paused), .alarm(alarm), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%06h expected=%06h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int dispObserved();
    return int'({hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones});
  endfunction

  function automatic int dispOf(input int h, input int m, input int s);
    return ((h / 10) << 20) | ((h % 10) << 16) | ((m / 10) << 12) |
           ((m % 10) << 8) | ((s / 10) << 4) | (s % 10);
  endfunction

  task automatic modelReset();
    m_state = 0; m_h = 0; m_m = 0; m_s = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic modelStep(input bit c, input bit ss, input bit tk,
                           input bit ih, input bit im, input bit is);
    int total;
    total  = m_h * 3600 + m_m * 60 + m_s;
    m_done = 0;
    if (c) begin
      m_state = 0; m_h = 0; m_m = 0; m_s = 0; m_cnt = 0;
    end else if (ss) begin
      case (m_state)
        0: if (total > 0) m_state = 1;
        1: m_state = 2;
        2: m_state = 1;
        default: begin m_state = 0; m_cnt = 0; end
      endcase
    end else if (tk && m_state == 1 && total > 0) begin
      total = total - 1;
      m_h = total / 3600; m_m = (total / 60) % 60; m_s = total % 60;
      if (total == 0) begin m_state = 3; m_done = 1; end
    end else if (tk && m_state == 3) begin
      m_cnt++;
      if (m_cnt == ALARM) begin m_state = 0; m_cnt = 0; end
    end else if (m_state == 0) begin
      if (is) m_s = (m_s + 1) % 60;
      if (im) m_m = (m_m + 1) % 60;
      if (ih) m_h = (m_h + 1) % 24;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".disp"}, dispObserved(), dispOf(m_h, m_m, m_s));
    checkOutput({tag, ".stat"}, int'({running, paused, alarm, done_pulse}),
                ((m_state == 1) << 3) | ((m_state == 2) << 2) | ((m_state == 3) << 1) | m_done);
  endtask

  // Holds the pulses for exactly one rising edge, then checks against the model.
  task automatic applyStimulus(input bit c, input bit ss, input bit tk,
                               input bit ih, input bit im, input bit is);
    cancel = c; start_stop = ss; tick_1hz = tk;
    inc_hour = ih; inc_min = im; inc_sec = is;
    @(posedge clk);
    #1;
    cancel = 0; start_stop = 0; tick_1hz = 0;
    inc_hour = 0; inc_min = 0; inc_sec = 0;
    modelStep(c, ss, tk, ih, im, is);
    checkAll("step");
  endtask

  task automatic repeatStim(input int n, input bit ss, input bit tk,
                            input bit ih, input bit im, input bit is);
    for (int i = 0; i < n; i++) applyStimulus(0, ss, tk, ih, im, is);
  endtask

  initial begin
    rst_n = 0;
    cancel = 0; start_stop = 0; tick_1hz = 0;
    inc_hour = 0; inc_min = 0; inc_sec = 0;
    modelReset();
    #12;
    checkOutput("reset.disp", dispObserved(), 0);
    checkOutput("reset.stat", int'({running, paused, alarm, done_pulse}), 0);
    rst_n = 1;

    $display("[TB] full countdown 00:01:03 to alarm and back to idle");
    repeatStim(3, 0, 0, 0, 0, 1);
    repeatStim(1, 0, 0, 0, 1, 0);
    checkOutput("preset", dispObserved(), 24'h000103);
    repeatStim(1, 1, 0, 0, 0, 0);
    repeatStim(62, 0, 1, 0, 0, 0);
    checkOutput("at1s", dispObserved(), 24'h000001);
    repeatStim(1, 0, 1, 0, 0, 0);
    checkOutput("expire.done", int'({alarm, done_pulse}), 3);
    repeatStim(1, 0, 0, 0, 0, 0);
    checkOutput("done.once", int'({alarm, done_pulse}), 2);
    repeatStim(9, 0, 1, 0, 0, 0);
    checkOutput("alarm9", int'(alarm), 1);
    repeatStim(1, 0, 1, 0, 0, 0);
    checkOutput("alarm10", int'({running, paused, alarm}), 0);

    $display("[TB] hour borrow 10->09 and 20->19");
    repeatStim(10, 0, 0, 1, 0, 0);
    repeatStim(1, 1, 1, 0, 0, 0);
    repeatStim(1, 0, 1, 0, 0, 0);
    checkOutput("hr10", dispObserved(), 24'h095959);
    applyStimulus(1, 0, 0, 0, 0, 0);
    repeatStim(20, 0, 0, 1, 0, 0);
    repeatStim(1, 1, 0, 0, 0, 0);
    repeatStim(1, 0, 1, 0, 0, 0);
    checkOutput("hr20", dispObserved(), 24'h195959);
    applyStimulus(1, 0, 0, 0, 0, 0);

    $display("[TB] preset field wrap and simultaneous edits");
    repeatStim(1, 0, 0, 0, 1, 0);
    repeatStim(60, 0, 0, 0, 0, 1);
    checkOutput("secwrap", dispObserved(), 24'h000100);
    repeatStim(24, 0, 0, 1, 0, 0);
    checkOutput("hrwrap", dispObserved(), 24'h000100);
    applyStimulus(1, 0, 0, 0, 0, 0);
    repeatStim(1, 0, 0, 1, 1, 1);
    checkOutput("allinc", dispObserved(), 24'h010101);
    applyStimulus(1, 0, 0, 0, 0, 0);

    $display("[TB] pause, resume, expire and acknowledge");
    repeatStim(5, 0, 0, 0, 0, 1);
    repeatStim(1, 1, 0, 0, 0, 0);
    repeatStim(2, 0, 1, 0, 0, 0);
    repeatStim(1, 1, 0, 0, 0, 0);
    repeatStim(5, 0, 1, 0, 0, 0);
    checkOutput("paused.hold", dispObserved(), 24'h000003);
    checkOutput("paused.flag", int'({running, paused}), 1);
    repeatStim(1, 1, 0, 0, 0, 0);
    repeatStim(3, 0, 1, 0, 0, 0);
    checkOutput("expired", int'(alarm), 1);
    repeatStim(1, 1, 0, 0, 0, 0);
    checkOutput("ack", int'({running, paused, alarm}), 0);

    $display("[TB] start at zero and cancel beating tick");
    repeatStim(1, 1, 0, 0, 0, 0);
    checkOutput("zerostart", int'(running), 0);
    repeatStim(5, 0, 0, 0, 1, 0);
    repeatStim(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("canceltick", dispObserved(), 0);

    $display("[TB] asynchronous reset mid-countdown");
    repeatStim(1, 0, 0, 1, 0, 0);
    repeatStim(1, 1, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    modelReset();
    checkOutput("areset.disp", dispObserved(), 0);
    checkOutput("areset.stat", int'({running, paused, alarm, done_pulse}), 0);
    #2 rst_n = 1;
    repeatStim(2, 0, 1, 0, 0, 0);

    $display("[TB] randomized pulses");
    for (int i = 0; i < 4000; i++) begin
      int r;
      int k;
      r = $urandom_range(0, 99);
      if (r < 2)       applyStimulus(1, 0, 0, 0, 0, 0);
      else if (r < 9)  applyStimulus(0, 1, 0, 0, 0, 0);
      else if (r < 55) applyStimulus(0, 0, 1, 0, 0, 0);
      else if (r < 80) begin
        k = $urandom_range(0, 9);
        if (k < 7) applyStimulus(0, 0, $urandom_range(0, 1), 0, 0, 1);
        else       applyStimulus(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1);
      end
      else             applyStimulus(0, 0, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
